// File: rtl/div_seq_4b_pkg.sv
// div_seq_4b_pkg
// Shared definitions for the sequential restoring divider: the default
// operand width and the controller state encoding (IDLE=0, CALC=1, DONE=2).
// No ports; imported by the divider, its step datapath and the bench.
package div_seq_4b_pkg;

    // Default operand/quotient/remainder width of the divider.
    localparam int DEF_WIDTH = 4;

    // Controller states, two-bit encoding shared with the bench.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// div_step
// One combinational restoring-division step: shift {pr, wq} left by one,
// then subtract den from the partial remainder when it fits and record the
// outcome in the new quotient LSB.
// Ports:
//   pr       in  WIDTH+1  current partial remainder
//   wq       in  WIDTH    working quotient (holds remaining dividend bits)
//   den      in  WIDTH    divisor
//   pr_next  out WIDTH+1  partial remainder after this step
//   wq_next  out WIDTH    working quotient after this step
module div_step
    import div_seq_4b_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   pr,
    input  logic [WIDTH-1:0] wq,
    input  logic [WIDTH-1:0] den,
    output logic [WIDTH:0]   pr_next,
    output logic [WIDTH-1:0] wq_next
);

    logic [WIDTH:0] shifted_s;
    logic           fits_s;

    // Shift, compare and conditionally subtract.
    always_comb begin
        shifted_s = {pr[WIDTH-1:0], wq[WIDTH-1]};
        // A set bit shifted out of pr means the true value exceeds any den;
        // the modular subtraction below still yields the correct remainder.
        // In normal operation pr < den so that bit is always clear.
        fits_s    = pr[WIDTH] | (shifted_s >= {1'b0, den});
        pr_next   = shifted_s;
        wq_next   = {wq[WIDTH-2:0], 1'b0};
        if (fits_s) begin
            pr_next    = shifted_s - {1'b0, den};
            wq_next[0] = 1'b1;
        end else begin
            pr_next    = shifted_s;
            wq_next[0] = 1'b0;
        end
    end

endmodule

// File: rtl/div_seq_4b.sv
// div_seq_4b
// Sequential restoring divider, one quotient bit per clock, with a
// start/done handshake and divide-by-zero detection (no iteration when the
// divisor is zero).
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   start      in   1      request a division (only honoured in IDLE)
//   num        in   WIDTH  dividend, sampled with start
//   den        in   WIDTH  divisor, sampled with start
//   busy       out  1      high while iterating
//   done       out  1      one-cycle completion pulse
//   quotient   out  WIDTH  registered quotient
//   remainder  out  WIDTH  registered remainder
//   div_zero   out  1      last accepted request had den == 0
module div_seq_4b
    import div_seq_4b_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       state_r;
    div_state_t       state_nxt_s;
    logic [WIDTH-1:0] den_r;
    logic [WIDTH:0]   pr_r;
    logic [WIDTH-1:0] wq_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH:0]   pr_step_s;
    logic [WIDTH-1:0] wq_step_s;
    logic             last_step_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .pr      (pr_r),
        .wq      (wq_r),
        .den     (den_r),
        .pr_next (pr_step_s),
        .wq_next (wq_step_s)
    );

    assign last_step_s = (cnt_r == LAST_STEP);

    // Next-state logic of the controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (den == {WIDTH{1'b0}}) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_CALC;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (last_step_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered busy/done decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy    <= (state_nxt_s == ST_CALC);
            done    <= (state_nxt_s == ST_DONE);
        end
    end

    // Operand latch, iteration datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            den_r     <= {WIDTH{1'b0}};
            pr_r      <= {(WIDTH + 1){1'b0}};
            wq_r      <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            quotient  <= {WIDTH{1'b0}};
            remainder <= {WIDTH{1'b0}};
            div_zero  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        den_r <= den;
                        if (den == {WIDTH{1'b0}}) begin
                            // Flag and finish at once; the dividend is
                            // reported back as the remainder.
                            quotient  <= {WIDTH{1'b1}};
                            remainder <= num;
                            div_zero  <= 1'b1;
                        end else begin
                            pr_r  <= {(WIDTH + 1){1'b0}};
                            wq_r  <= num;
                            cnt_r <= {CNT_W{1'b0}};
                        end
                    end
                end
                ST_CALC: begin
                    pr_r  <= pr_step_s;
                    wq_r  <= wq_step_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_step_s) begin
                        quotient  <= wq_step_s;
                        remainder <= pr_step_s[WIDTH-1:0];
                        div_zero  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_4b.sv
// tb_div_seq_4b
// Self-checking bench for div_seq_4b. Expected quotient/remainder come from
// plain integer division in the bench; timing expectations come from the
// handshake rules (latency, busy length, done pulse width, period).
module tb_div_seq_4b;
    import div_seq_4b_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] num = 4'd0;
    logic [3:0] den = 4'd0;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    int checks = 0;
    int errors = 0;

    div_seq_4b #(.WIDTH(DEF_WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num       (num),
        .den       (den),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Reference model: unsigned division with the divide-by-zero convention.
    function automatic void ref_div(input int n, input int d, output int q,
                                    output int r, output int z);
        if (d == 0) begin
            q = 15; r = n; z = 1;
        end else begin
            q = n / d; r = n % d; z = 0;
        end
    endfunction

    // Drive one request (called at a negedge) and follow it to done.
    // lat = samples after the start edge until done (-1 on timeout).
    task automatic run_div(input logic [3:0] n, input logic [3:0] d,
                           output int lat, output int busy_n,
                           output bit overlap, output bit moved,
                           output bit done_after);
        logic [3:0] q0, r0;
        q0 = quotient; r0 = remainder;
        num = n; den = d; start = 1'b1;
        lat = -1; busy_n = 0; overlap = 1'b0; moved = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                num = 4'($urandom);
                den = 4'($urandom);
            end
            if (busy) busy_n++;
            if (busy && done) overlap = 1'b1;
            if (busy && (quotient !== q0 || remainder !== r0)) moved = 1'b1;
            if (done) begin
                lat = c;
                break;
            end
        end
        @(posedge clk); @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, div_zero} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_zero});
        end
        checks++;
        if ({quotient, remainder} !== 8'h00) begin
            errors++; $display("FAIL reset_results: got q=%0d r=%0d expected 0 0", quotient, remainder);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL idle_flags: got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_basic();
        int lat, bn; bit ov, mv, da;
        run_div(4'd13, 4'd4, lat, bn, ov, mv, da);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d expected 5", lat); end
        checks++;
        if (bn !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 4", bn); end
        checks++;
        if (ov || mv || da) begin
            errors++; $display("FAIL basic_handshake: overlap=%0d moved=%0d done_after=%0d expected 0 0 0", ov, mv, da);
        end
        checks++;
        if ({quotient, remainder, div_zero} !== {4'd3, 4'd1, 1'b0}) begin
            errors++; $display("FAIL basic_result: got q=%0d r=%0d z=%0d expected 3 1 0", quotient, remainder, div_zero);
        end
    endtask

    task automatic test_vectors();
        logic [3:0] ns [3];
        logic [3:0] ds [3];
        int lat, bn, q, r, z; bit ov, mv, da;
        ns[0] = 4'd15; ds[0] = 4'd1;
        ns[1] = 4'd3;  ds[1] = 4'd9;
        ns[2] = 4'd0;  ds[2] = 4'd5;
        for (int i = 0; i < 3; i++) begin
            run_div(ns[i], ds[i], lat, bn, ov, mv, da);
            ref_div(int'(ns[i]), int'(ds[i]), q, r, z);
            checks++;
            if (lat !== 5 || int'(quotient) !== q || int'(remainder) !== r || int'(div_zero) !== z) begin
                errors++;
                $display("FAIL vector_%0d: got lat=%0d q=%0d r=%0d z=%0d expected 5 %0d %0d %0d",
                         i, lat, quotient, remainder, div_zero, q, r, z);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat, bn; bit ov, mv, da;
        run_div(4'd7, 4'd0, lat, bn, ov, mv, da);
        checks++;
        if (lat !== 1 || bn !== 0 || da) begin
            errors++; $display("FAIL dz_timing: got lat=%0d busy=%0d done_after=%0d expected 1 0 0", lat, bn, da);
        end
        checks++;
        if ({quotient, remainder, div_zero} !== {4'hF, 4'd7, 1'b1}) begin
            errors++; $display("FAIL dz_result: got q=%0d r=%0d z=%0d expected 15 7 1", quotient, remainder, div_zero);
        end
        run_div(4'd6, 4'd4, lat, bn, ov, mv, da);
        checks++;
        if ({quotient, remainder, div_zero} !== {4'd1, 4'd2, 1'b0}) begin
            errors++; $display("FAIL dz_clear: got q=%0d r=%0d z=%0d expected 1 2 0", quotient, remainder, div_zero);
        end
    endtask

    task automatic test_ignore_start();
        int pulses; logic [3:0] q_at, r_at;
        pulses = 0; q_at = 4'd0; r_at = 4'd0;
        num = 4'd11; den = 4'd3; start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); @(negedge clk);
            // Scramble operands and keep re-requesting while iterating.
            start = (c <= 3) ? 1'b1 : 1'b0;
            num = 4'($urandom);
            den = 4'($urandom);
            if (done) begin
                pulses++; q_at = quotient; r_at = remainder;
            end
        end
        start = 1'b0;
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", pulses); end
        checks++;
        if ({q_at, r_at} !== {4'd3, 4'd2}) begin
            errors++; $display("FAIL ignore_result: got q=%0d r=%0d expected 3 2", q_at, r_at);
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat, bn, seen; bit ov, mv, da;
        num = 4'd14; den = 4'd3; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, div_zero, quotient, remainder} !== 11'd0) begin
            errors++; $display("FAIL mid_reset_outputs: got busy=%0d done=%0d z=%0d q=%0d r=%0d expected all 0",
                               busy, done, div_zero, quotient, remainder);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL mid_reset_no_done: got %0d active cycles expected 0", seen); end
        run_div(4'd9, 4'd2, lat, bn, ov, mv, da);
        checks++;
        if (lat !== 5 || {quotient, remainder} !== {4'd4, 4'd1}) begin
            errors++; $display("FAIL mid_reset_fresh: got lat=%0d q=%0d r=%0d expected 5 4 1", lat, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        int gap, first, bad;
        num = 4'd12; den = 5'd5; start = 1'b1;
        first = -1; bad = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); @(negedge clk);
            if (done) begin first = c; break; end
        end
        checks++;
        if (first !== 5) begin errors++; $display("FAIL b2b_first: got %0d expected 5", first); end
        for (int p = 0; p < 3; p++) begin
            gap = -1;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk); @(negedge clk);
                if ({quotient, remainder} !== {4'd2, 4'd2}) bad++;
                if (done) begin gap = c; break; end
            end
            checks++;
            if (gap !== 6) begin errors++; $display("FAIL b2b_period_%0d: got %0d expected 6", p, gap); end
        end
        start = 1'b0;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL b2b_stable: got %0d unstable samples expected 0", bad); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_random();
        int lat, bn, q, r, z, exp_lat, exp_bn; bit ov, mv, da;
        logic [3:0] n, d;
        for (int i = 0; i < 40; i++) begin
            n = 4'($urandom);
            d = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
            run_div(n, d, lat, bn, ov, mv, da);
            ref_div(int'(n), int'(d), q, r, z);
            exp_lat = (d == 4'd0) ? 1 : 5;
            exp_bn  = (d == 4'd0) ? 0 : 4;
            checks++;
            if (lat !== exp_lat || bn !== exp_bn || ov || mv || da ||
                int'(quotient) !== q || int'(remainder) !== r || int'(div_zero) !== z) begin
                errors++;
                $display("FAIL random_%0d %0d/%0d: got lat=%0d busy=%0d q=%0d r=%0d z=%0d ov=%0d mv=%0d expected lat=%0d busy=%0d q=%0d r=%0d z=%0d",
                         i, n, d, lat, bn, quotient, remainder, div_zero, ov, mv, exp_lat, exp_bn, q, r, z);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_div_zero();
        test_ignore_start();
        test_reset_mid_calc();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
